branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Branch resolution sequencer for the decode stage of the pipelined MIPS core. Accepts one branch at a time, waits until forwarded operands are ready, evaluates the branch condition (beq/bne/bltz/bgez/blez/bgtz), and returns a one-cycle registered verdict that drives next-PC selection. While it works it stalls fetch/decode. It also keeps saturating taken/total statistics and flags operand-wait timeouts.

## Interface
- `WIDTH`, 32, operand width
- `MAX_WAIT`, 15, maximum WAIT cycles before timeout (≥1)
- `CNT_W`, 16, statistics counter width
- `clk` input 1, the single clock; all state updates on its rising edge
- `reset` input 1, synchronous, active-high
- `br_valid` input 1, branch instruction present in D stage
- `br_type` input 3, 0=beq 1=bne 2=bltz 3=bgez 4=blez 5=bgtz, 6/7 reserved
- `rs_val` input WIDTH, forwarded rs operand
- `rt_val` input WIDTH, forwarded rt operand, used by beq/bne only
- `rs_rdy` input 1, rs_val valid this cycle
- `rt_rdy` input 1, rt_val valid this cycle, ignored for types 2–7
- `flush` input 1, kills any in-flight evaluation
- `stall` output 1, freeze PC and F/D register (combinational from state and inputs)
- `br_done` output 1, registered one-cycle verdict strobe
- `br_taken` output 1, registered outcome, valid only while br_done=1, else 0
- `br_err` output 1, registered one-cycle timeout strobe, coincident with br_done
- `taken_cnt` output CNT_W, saturating count of taken branches
- `total_cnt` output CNT_W, saturating count of completed branches, including timeouts

## Operation
- States: IDLE, WAIT, DONE. Reset sets state IDLE, and sets br_done, br_taken, br_err, taken_cnt, total_cnt and the wait counter to 0.
- Ready definition: `ready = rs_rdy & (rt_rdy | br_type_eff>1)`. br_type_eff is br_type in IDLE and the latched type in WAIT.
- IDLE:
  - If br_valid & ready, evaluate the condition on the current operands, register the verdict, and go to DONE.
  - If br_valid & !ready, latch br_type, clear the wait counter, and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - Each cycle without ready, the wait counter increments.
  - If ready, evaluate on the current rs_val/rt_val and the latched type, then go to DONE.
  - If ready is still 0 when the counter equals MAX_WAIT, go to DONE with br_taken=0 and br_err=1.
- DONE: br_done=1 for exactly this cycle, then unconditionally return to IDLE. A br_valid seen in DONE is not accepted. A new branch is accepted from IDLE the following cycle at the earliest.
- Conditions, with rs as two's complement:
  - beq: rs==rt
  - bne: rs!=rt
  - bltz: rs[WIDTH-1]
  - bgez: !rs[WIDTH-1]
  - blez: rs[WIDTH-1] | (rs==0)
  - bgtz: !rs[WIDTH-1] & (rs!=0)
  - Types 6/7: ready depends on rs_rdy only; they resolve not-taken with br_err=0.
- stall = (IDLE & br_valid & !flush) | WAIT. stall=0 in DONE, so the branch leaves D on the done cycle.
- Statistics update on entry to DONE:
  - total_cnt increments.
  - taken_cnt increments if the registered verdict is taken.
  - Each counter holds at 2^CNT_W−1; no wrap.
- flush has priority over every transition except reset:
  - Any state goes to IDLE next cycle.
  - No br_done is produced and counters do not change.
  - If flush arrives in the same cycle as a DONE entry condition, the branch is dropped.
  - If flush is high while the FSM is already in DONE, br_done still shows this cycle (already registered).
- Reset mid-operation (WAIT or DONE): the next cycle is IDLE with all outputs 0. Reset overrides flush.

## Timing
- Operands ready at accept: br_valid in cycle N gives stall=1 in N, and br_done/br_taken in N+1.
- Operands ready after k wait cycles: br_done in N+k+1, stall=1 in cycles N..N+k.
- Timeout: br_valid at N with ready never asserted gives br_done=br_err=1 in cycle N+MAX_WAIT+1.
- Minimum spacing between two accepted branches is 2 cycles (DONE, then IDLE).
- Statistics counters reflect a completed branch in the cycle after its br_done.

## Test plan
- Reset, then idle 5 cycles: all outputs 0, stall=0. Assert reset while in WAIT: next cycle all outputs 0, state IDLE.
- bltz, rs=32'hFFFF_FFFF, rs_rdy=1 at cycle N: stall=1 at N; br_done=1 and br_taken=1 at N+1; taken_cnt=1 and total_cnt=1 at N+2. Repeat with bgtz, rs=0: br_taken=0.
- beq, rs=rt=5, rt_rdy low for 3 cycles: stall high N..N+3, br_done/br_taken=1 at N+4. Repeat with bne and rt_rdy held 0 but type bltz: rt_rdy ignored.
- bgez, rs_rdy held 0 with MAX_WAIT=15: br_done=br_err=1, br_taken=0 at N+16; total_cnt increments, taken_cnt unchanged.
- flush during WAIT at cycle N+2: IDLE at N+3, no br_done, counters unchanged. Flush coincident with ready: branch dropped, no br_done.
- CNT_W=2, 5 taken branches: taken_cnt and total_cnt saturate at 3. br_valid held through DONE: second branch accepted only in the following IDLE cycle.

Source files
------------

// File: rtl/branch_ctrl.sv
// Branch resolution sequencer for the decode stage. It waits for forwarded operands,
// evaluates the branch condition and returns a one-cycle registered verdict.
module branch_ctrl #(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_valid,
    input  logic [2:0]       br_type,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             rs_rdy,
    input  logic             rt_rdy,
    input  logic             flush,
    output logic             stall,
    output logic             br_done,
    output logic             br_taken,
    output logic             br_err,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] total_cnt,
    output logic [1:0]       fsm_state
);

    // Handshake: a branch is offered by br_valid and consumed when the FSM leaves
    // IDLE; the consumer sees it resolved when br_done pulses for one cycle.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    state_t            state_q;
    logic [2:0]        type_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [2:0]        type_eff;
    logic              ready;
    logic              verdict;

    function automatic logic eval_cond(input logic [2:0] t,
                                       input logic [WIDTH-1:0] rs,
                                       input logic [WIDTH-1:0] rt);
        logic neg;
        logic zero;
        neg  = rs[WIDTH-1];
        zero = (rs == '0);
        case (t)
            3'd0:    eval_cond = (rs == rt);
            3'd1:    eval_cond = (rs != rt);
            3'd2:    eval_cond = neg;
            3'd3:    eval_cond = !neg;
            3'd4:    eval_cond = neg | zero;
            3'd5:    eval_cond = !neg & !zero;
            default: eval_cond = 1'b0;
        endcase
    endfunction

    always_comb begin
        type_eff = (state_q == WAIT) ? type_q : br_type;
        ready    = rs_rdy & (rt_rdy | (type_eff > 3'd1));
        verdict  = eval_cond(type_eff, rs_val, rt_val);
        stall    = ((state_q == IDLE) & br_valid & !flush) | (state_q == WAIT);
    end

    assign fsm_state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            type_q    <= '0;
            wait_cnt  <= '0;
            br_done   <= 1'b0;
            br_taken  <= 1'b0;
            br_err    <= 1'b0;
            taken_cnt <= '0;
            total_cnt <= '0;
        end else begin
            br_done  <= 1'b0;
            br_taken <= 1'b0;
            br_err   <= 1'b0;

            // The verdict has already been delivered while in DONE, so it is counted
            // even if a flush shows up in that same cycle.
            if (state_q == DONE) begin
                if (total_cnt != {CNT_W{1'b1}})
                    total_cnt <= total_cnt + CNT_W'(1);
                if (br_taken && (taken_cnt != {CNT_W{1'b1}}))
                    taken_cnt <= taken_cnt + CNT_W'(1);
            end

            if (flush) begin
                state_q  <= IDLE;
                wait_cnt <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (br_valid) begin
                            if (ready) begin
                                state_q  <= DONE;
                                br_done  <= 1'b1;
                                br_taken <= verdict;
                            end else begin
                                state_q  <= WAIT;
                                type_q   <= br_type;
                                wait_cnt <= '0;
                            end
                        end
                    end
                    WAIT: begin
                        if (ready) begin
                            state_q  <= DONE;
                            br_done  <= 1'b1;
                            br_taken <= verdict;
                        end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                            // The counter value before this cycle's increment, so the
                            // timeout fires after exactly MAX_WAIT waiting cycles.
                            state_q <= DONE;
                            br_done <= 1'b1;
                            br_err  <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: cycle-exact checks of stall, verdict, timeout,
// flush, reset and counter saturation against hand-computed values.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        br_valid;
    logic [2:0]  br_type;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        rs_rdy;
    logic        rt_rdy;
    logic        flush;

    logic        stall, br_done, br_taken, br_err;
    logic [15:0] taken_cnt, total_cnt;
    logic [1:0]  fsm_state;

    logic        s_stall, s_done, s_taken, s_err;
    logic [1:0]  s_taken_cnt, s_total_cnt;
    logic [1:0]  s_state;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;

    always #5 clk = ~clk;

    branch_ctrl #(.WIDTH(32), .MAX_WAIT(15), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .br_valid(br_valid), .br_type(br_type),
        .rs_val(rs_val), .rt_val(rt_val), .rs_rdy(rs_rdy), .rt_rdy(rt_rdy),
        .flush(flush), .stall(stall), .br_done(br_done), .br_taken(br_taken),
        .br_err(br_err), .taken_cnt(taken_cnt), .total_cnt(total_cnt),
        .fsm_state(fsm_state)
    );

    branch_ctrl #(.WIDTH(32), .MAX_WAIT(15), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .br_valid(br_valid), .br_type(br_type),
        .rs_val(rs_val), .rt_val(rt_val), .rs_rdy(rs_rdy), .rt_rdy(rt_rdy),
        .flush(flush), .stall(s_stall), .br_done(s_done), .br_taken(s_taken),
        .br_err(s_err), .taken_cnt(s_taken_cnt), .total_cnt(s_total_cnt),
        .fsm_state(s_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance into the next cycle; inputs set afterwards apply to that cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive(input logic v, input logic [2:0] t, input logic [31:0] rs,
                         input logic [31:0] rt, input logic rsr, input logic rtr,
                         input logic fl);
        br_valid = v; br_type = t; rs_val = rs; rt_val = rt;
        rs_rdy = rsr; rt_rdy = rtr; flush = fl;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_counts(input string tag, input int tk, input int tot);
        check({tag, "_taken_cnt"}, {16'd0, taken_cnt}, tk);
        check({tag, "_total_cnt"}, {16'd0, total_cnt}, tot);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            tick();
            settle();
            check("idle_stall", stall, 0);
            check("idle_done", br_done, 0);
            check("idle_taken", br_taken, 0);
            check("idle_err", br_err, 0);
            check("idle_state", fsm_state, ST_IDLE);
        end
        check_counts("idle", 0, 0);

        // bltz, negative rs, ready at accept
        tick(); drive(1'b1, 3'd2, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b0); settle();
        check("bltz_stall_n", stall, 1);
        tick(); idle_inputs(); settle();
        check("bltz_done", br_done, 1);
        check("bltz_taken", br_taken, 1);
        check("bltz_err", br_err, 0);
        check("bltz_stall_done", stall, 0);
        tick(); settle();
        check("bltz_done_clear", br_done, 0);
        check("bltz_taken_clear", br_taken, 0);
        check_counts("bltz", 1, 1);

        // bgtz, rs=0 -> not taken
        tick(); drive(1'b1, 3'd5, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0); settle();
        check("bgtz_stall_n", stall, 1);
        tick(); idle_inputs(); settle();
        check("bgtz_done", br_done, 1);
        check("bgtz_taken", br_taken, 0);
        tick(); settle();
        check_counts("bgtz", 1, 2);

        // beq rs=rt=5, rt_rdy low three cycles
        tick(); drive(1'b1, 3'd0, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0); settle();
        check("beq_stall_n", stall, 1);
        for (int i = 1; i <= 2; i++) begin
            tick(); drive(1'b0, 3'd0, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0); settle();
            check("beq_stall_wait", stall, 1);
            check("beq_state_wait", fsm_state, ST_WAIT);
            check("beq_done_wait", br_done, 0);
        end
        tick(); drive(1'b0, 3'd0, 32'd5, 32'd5, 1'b1, 1'b1, 1'b0); settle();
        check("beq_stall_n3", stall, 1);
        tick(); idle_inputs(); settle();
        check("beq_done", br_done, 1);
        check("beq_taken", br_taken, 1);
        tick(); settle();
        check_counts("beq", 2, 3);

        // bne with rs==rt after one wait cycle -> not taken
        tick(); drive(1'b1, 3'd1, 32'd9, 32'd9, 1'b1, 1'b0, 1'b0); settle();
        tick(); drive(1'b0, 3'd0, 32'd9, 32'd9, 1'b1, 1'b1, 1'b0); settle();
        check("bne_stall_wait", stall, 1);
        tick(); idle_inputs(); settle();
        check("bne_done", br_done, 1);
        check("bne_taken", br_taken, 0);

        // bltz with rt_rdy held low resolves immediately
        tick(); drive(1'b1, 3'd2, 32'h8000_0000, 32'd0, 1'b1, 1'b0, 1'b0); settle();
        check("bltz_rt_stall", stall, 1);
        tick(); idle_inputs(); settle();
        check("bltz_rt_done", br_done, 1);
        check("bltz_rt_taken", br_taken, 1);
        tick(); settle();
        check_counts("bltz_rt", 3, 5);

        // reserved type 6: not taken, no error
        tick(); drive(1'b1, 3'd6, 32'h8000_0000, 32'd0, 1'b1, 1'b0, 1'b0); settle();
        tick(); idle_inputs(); settle();
        check("rsv_done", br_done, 1);
        check("rsv_taken", br_taken, 0);
        check("rsv_err", br_err, 0);
        tick(); settle();
        check_counts("rsv", 3, 6);

        // bgez timeout
        tick(); drive(1'b1, 3'd3, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0); settle();
        check("to_stall_n", stall, 1);
        for (int i = 1; i <= 15; i++) begin
            tick(); idle_inputs(); settle();
            check("to_stall_wait", stall, 1);
            check("to_done_wait", br_done, 0);
        end
        tick(); settle();
        check("to_done", br_done, 1);
        check("to_err", br_err, 1);
        check("to_taken", br_taken, 0);
        check("to_stall_done", stall, 0);
        tick(); settle();
        check("to_err_clear", br_err, 0);
        check_counts("to", 3, 7);

        // reset while in WAIT
        tick(); drive(1'b1, 3'd3, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0); settle();
        tick(); idle_inputs(); reset = 1'b1; settle();
        check("rst_pre_state", fsm_state, ST_WAIT);
        tick(); reset = 1'b0; settle();
        check("rst_state", fsm_state, ST_IDLE);
        check("rst_stall", stall, 0);
        check("rst_done", br_done, 0);
        check("rst_err", br_err, 0);
        check_counts("rst", 0, 0);

        // flush during WAIT
        tick(); drive(1'b1, 3'd0, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0); settle();
        tick(); idle_inputs(); settle();
        check("fw_state_wait", fsm_state, ST_WAIT);
        tick(); drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1); settle();
        tick(); idle_inputs(); settle();
        check("fw_state", fsm_state, ST_IDLE);
        check("fw_stall", stall, 0);
        check("fw_done", br_done, 0);
        tick(); settle();
        check("fw_done_later", br_done, 0);
        check_counts("fw", 0, 0);

        // flush coincident with ready in IDLE
        tick(); drive(1'b1, 3'd2, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b1); settle();
        check("fi_stall", stall, 0);
        tick(); idle_inputs(); settle();
        check("fi_done", br_done, 0);
        check("fi_state", fsm_state, ST_IDLE);

        // flush coincident with ready in WAIT
        tick(); drive(1'b1, 3'd0, 32'd3, 32'd3, 1'b1, 1'b0, 1'b0); settle();
        tick(); drive(1'b0, 3'd0, 32'd3, 32'd3, 1'b1, 1'b1, 1'b1); settle();
        tick(); idle_inputs(); settle();
        check("fr_done", br_done, 0);
        check("fr_state", fsm_state, ST_IDLE);
        tick(); settle();
        check_counts("fr", 0, 0);

        // br_valid held through DONE: back-to-back spacing of two cycles
        tick(); drive(1'b1, 3'd5, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0); settle();
        check("hold_stall_n", stall, 1);
        tick(); settle();
        check("hold_done1", br_done, 1);
        check("hold_stall_done", stall, 0);
        tick(); settle();
        check("hold_done_gap", br_done, 0);
        check("hold_stall_re", stall, 1);
        check_counts("hold_mid", 1, 1);
        tick(); idle_inputs(); settle();
        check("hold_done2", br_done, 1);
        check("hold_taken2", br_taken, 1);
        tick(); settle();
        check_counts("hold", 2, 2);

        // saturation of the narrow counters
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(); drive(1'b1, 3'd2, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b0);
            tick(); idle_inputs();
        end
        tick(); settle();
        check("sat_taken_cnt", {30'd0, s_taken_cnt}, 3);
        check("sat_total_cnt", {30'd0, s_total_cnt}, 3);
        check_counts("wide", 5, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
